// File: rtl/s3_chien_forney.sv
// Decoder stage 3: Chien search plus Forney magnitudes for a t=2 RS code over GF(2^8), poly 0x11D, fcr=0.
// Define S3_CHIEN_FORNEY_ERRCNT_EN to add the chien_errcnt root-count output.

module gf2m8_multi (
    input  logic [7:0] a_i,
    input  logic [7:0] b_i,
    output logic [7:0] p_o
);
    logic [7:0] acc;
    logic [7:0] sh;

    always_comb begin
        acc = 8'h00;
        sh  = a_i;
        for (int i = 0; i < 8; i++) begin
            if (b_i[i]) acc = acc ^ sh;
            sh = {sh[6:0], 1'b0} ^ (sh[7] ? 8'h1D : 8'h00);
        end
        p_o = acc;
    end
endmodule

module gf2m8_inverse (
    input  logic [7:0] a_i,
    output logic [7:0] inv_o
);
    function automatic logic [7:0] gfMul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] acc;
        logic [7:0] sh;
        acc = 8'h00;
        sh  = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) acc = acc ^ sh;
            sh = {sh[6:0], 1'b0} ^ (sh[7] ? 8'h1D : 8'h00);
        end
        return acc;
    endfunction

    logic [7:0] sq;
    logic [7:0] res;

    // x^254 = x^2 * x^4 * ... * x^128; maps 0 to 0.
    always_comb begin
        sq  = a_i;
        res = 8'h01;
        for (int i = 1; i < 8; i++) begin
            sq  = gfMul(sq, sq);
            res = gfMul(res, sq);
        end
        inv_o = res;
    end
endmodule

module s3_chien_forney #(
    parameter int N  = 255,
    parameter int IW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          kes_done,
    input  logic [7:0]    rs_lambda0,
    input  logic [7:0]    rs_lambda1,
    input  logic [7:0]    rs_lambda2,
    input  logic [7:0]    rs_omega0,
    input  logic [7:0]    rs_omega1,
    output logic          kes_rdy,
    output logic          chien_vld,
    output logic [IW-1:0] chien_idx,
    output logic [7:0]    chien_mag,
    output logic          chien_done,
    output logic          chien_fail,
    output logic          chien_ovf
`ifdef S3_CHIEN_FORNEY_ERRCNT_EN
   ,output logic [1:0]    chien_errcnt
`endif
);
    function automatic logic [7:0] alphaPow(input int e);
        logic [7:0] v;
        v = 8'h01;
        for (int i = 0; i < e; i++) v = {v[6:0], 1'b0} ^ (v[7] ? 8'h1D : 8'h00);
        return v;
    endfunction

    // Position j is evaluated at x = a^-j, so the sweep starts at a^-(N-1) = a^(256-N).
    localparam logic [7:0] ASHIFT1  = alphaPow(256 - N);
    localparam logic [7:0] ASHIFT2  = alphaPow(2 * (256 - N));
    localparam logic [7:0] XSTART   = alphaPow(N - 1);
    localparam logic [7:0] ALPHA1   = 8'h02;
    localparam logic [7:0] ALPHA2   = 8'h04;
    localparam logic [7:0] ALPHAINV = alphaPow(254);

    typedef enum logic {IDLE, RUN} state_t;

    state_t        state_q;
    logic          pendFull_q;
    logic [7:0]    pendL0_q, pendL1_q, pendL2_q, pendO0_q, pendO1_q;
    logic [7:0]    l0_q, l1_q, o0_q, t1_q, t2_q, w1_q, x_q;
    logic [IW-1:0] j_q;
    logic [1:0]    rootCnt_q;
    logic          badRoot_q;
    logic          chienVld_q, chienDone_q, chienFail_q, chienOvf_q;
    logic [IW-1:0] chienIdx_q;
    logic [7:0]    chienMag_q;
`ifdef S3_CHIEN_FORNEY_ERRCNT_EN
    logic [1:0]    chienErrcnt_q;
`endif

    logic [7:0] t1Load, t2Load, w1Load;
    logic [7:0] t1Step, t2Step, w1Step, xStep;
    logic [7:0] xOmega, l1Inv, magRaw;
    logic       lastBeat, loadNow, accept, isRoot, l1Zero;
    logic [1:0] rootCnt_d, deg;
    logic       badRoot_d, fail_d;

    gf2m8_multi mulL1  (.a_i(pendL1_q), .b_i(ASHIFT1),  .p_o(t1Load));
    gf2m8_multi mulL2  (.a_i(pendL2_q), .b_i(ASHIFT2),  .p_o(t2Load));
    gf2m8_multi mulO1  (.a_i(pendO1_q), .b_i(ASHIFT1),  .p_o(w1Load));
    gf2m8_multi mulT1  (.a_i(t1_q),     .b_i(ALPHA1),   .p_o(t1Step));
    gf2m8_multi mulT2  (.a_i(t2_q),     .b_i(ALPHA2),   .p_o(t2Step));
    gf2m8_multi mulW1  (.a_i(w1_q),     .b_i(ALPHA1),   .p_o(w1Step));
    gf2m8_multi mulX   (.a_i(x_q),      .b_i(ALPHAINV), .p_o(xStep));
    gf2m8_multi mulXO  (.a_i(x_q),      .b_i(o0_q ^ w1_q), .p_o(xOmega));
    gf2m8_inverse invL1 (.a_i(l1_q),    .inv_o(l1Inv));
    gf2m8_multi mulMag (.a_i(xOmega),   .b_i(l1Inv),    .p_o(magRaw));

    // The slot is also free in any cycle that moves it into the working registers.
    always_comb begin
        lastBeat  = (j_q == '0);
        loadNow   = pendFull_q && ((state_q == IDLE) || lastBeat);
        kes_rdy   = !pendFull_q || loadNow;
        accept    = kes_done && kes_rdy;
        isRoot    = ((l0_q ^ t1_q ^ t2_q) == 8'h00);
        l1Zero    = (l1_q == 8'h00);
        rootCnt_d = (isRoot && rootCnt_q != 2'd3) ? rootCnt_q + 2'd1 : rootCnt_q;
        badRoot_d = badRoot_q || (isRoot && l1Zero);
        deg       = (t2_q != 8'h00) ? 2'd2 : (!l1Zero ? 2'd1 : 2'd0);
        fail_d    = (rootCnt_d != deg) || badRoot_d;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            pendFull_q  <= 1'b0;
            pendL0_q    <= '0;
            pendL1_q    <= '0;
            pendL2_q    <= '0;
            pendO0_q    <= '0;
            pendO1_q    <= '0;
            l0_q        <= '0;
            l1_q        <= '0;
            o0_q        <= '0;
            t1_q        <= '0;
            t2_q        <= '0;
            w1_q        <= '0;
            x_q         <= '0;
            j_q         <= '0;
            rootCnt_q   <= '0;
            badRoot_q   <= 1'b0;
            chienVld_q  <= 1'b0;
            chienIdx_q  <= '0;
            chienMag_q  <= '0;
            chienDone_q <= 1'b0;
            chienFail_q <= 1'b0;
            chienOvf_q  <= 1'b0;
`ifdef S3_CHIEN_FORNEY_ERRCNT_EN
            chienErrcnt_q <= '0;
`endif
        end else begin
            if (accept) begin
                pendFull_q <= 1'b1;
                pendL0_q   <= rs_lambda0;
                pendL1_q   <= rs_lambda1;
                pendL2_q   <= rs_lambda2;
                pendO0_q   <= rs_omega0;
                pendO1_q   <= rs_omega1;
            end else if (loadNow) begin
                pendFull_q <= 1'b0;
            end
            if (kes_done && !kes_rdy) chienOvf_q <= 1'b1;

            chienVld_q  <= 1'b0;
            chienIdx_q  <= '0;
            chienMag_q  <= '0;
            chienDone_q <= 1'b0;
            chienFail_q <= 1'b0;
`ifdef S3_CHIEN_FORNEY_ERRCNT_EN
            chienErrcnt_q <= '0;
`endif

            if (state_q == RUN) begin
                chienVld_q <= 1'b1;
                chienIdx_q <= j_q;
                chienMag_q <= (isRoot && !l1Zero) ? magRaw : 8'h00;
                t1_q       <= t1Step;
                t2_q       <= t2Step;
                w1_q       <= w1Step;
                x_q        <= xStep;
                j_q        <= j_q - IW'(1);
                rootCnt_q  <= rootCnt_d;
                badRoot_q  <= badRoot_d;
                if (lastBeat) begin
                    chienDone_q <= 1'b1;
                    chienFail_q <= fail_d;
`ifdef S3_CHIEN_FORNEY_ERRCNT_EN
                    chienErrcnt_q <= rootCnt_d;
`endif
                    if (!pendFull_q) state_q <= IDLE;
                end
            end

            // Placed last so a reload on the final beat overrides the step updates above.
            if (loadNow) begin
                state_q   <= RUN;
                l0_q      <= pendL0_q;
                l1_q      <= pendL1_q;
                o0_q      <= pendO0_q;
                t1_q      <= t1Load;
                t2_q      <= t2Load;
                w1_q      <= w1Load;
                x_q       <= XSTART;
                j_q       <= IW'(N - 1);
                rootCnt_q <= '0;
                badRoot_q <= 1'b0;
            end
        end
    end

    assign chien_vld  = chienVld_q;
    assign chien_idx  = chienIdx_q;
    assign chien_mag  = chienMag_q;
    assign chien_done = chienDone_q;
    assign chien_fail = chienFail_q;
    assign chien_ovf  = chienOvf_q;
`ifdef S3_CHIEN_FORNEY_ERRCNT_EN
    assign chien_errcnt = chienErrcnt_q;
`endif
endmodule

// File: tb/tb_s3_chien_forney.sv
// Directed testbench for s3_chien_forney (N=255): single codewords, gapless back-to-back, overflow, mid-run reset.
// Checks chien_errcnt too when S3_CHIEN_FORNEY_ERRCNT_EN is defined.

module tb_s3_chien_forney;
    localparam int N  = 255;
    localparam int IW = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          kesDone;
    logic [7:0]    lam0, lam1, lam2, om0, om1;
    logic          kesRdy, vld, done, fail, ovf;
    logic [IW-1:0] idx;
    logic [7:0]    mag;
`ifdef S3_CHIEN_FORNEY_ERRCNT_EN
    logic [1:0]    errcnt;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    s3_chien_forney #(.N(N), .IW(IW)) dut (
        .clk        (clk),
        .rst        (rst),
        .kes_done   (kesDone),
        .rs_lambda0 (lam0),
        .rs_lambda1 (lam1),
        .rs_lambda2 (lam2),
        .rs_omega0  (om0),
        .rs_omega1  (om1),
        .kes_rdy    (kesRdy),
        .chien_vld  (vld),
        .chien_idx  (idx),
        .chien_mag  (mag),
        .chien_done (done),
        .chien_fail (fail),
        .chien_ovf  (ovf)
`ifdef S3_CHIEN_FORNEY_ERRCNT_EN
       ,.chien_errcnt (errcnt)
`endif
    );

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s at %0t: got %0h expected %0h", tag, $time, observed, expected);
        end
    endtask

    // Called at a negedge; kes_done is sampled by the following posedge.
    task automatic applyStimulus(input logic [7:0] l0, input logic [7:0] l1, input logic [7:0] l2,
                                 input logic [7:0] o0, input logic [7:0] o1);
        lam0 = l0; lam1 = l1; lam2 = l2; om0 = o0; om1 = o1;
        kesDone = 1'b1;
        @(negedge clk);
        kesDone = 1'b0;
    endtask

    // Expects the first beat visible now; returns one negedge after the last beat.
    task automatic checkStream(input string tag, input int expIdx, input logic [7:0] expMag,
                               input logic expFail, input logic [1:0] expCnt);
        int j;
        for (int k = 0; k < N; k++) begin
            j = N - 1 - k;
            checkOutput({tag, ".vld"},  32'(vld),  32'd1);
            checkOutput({tag, ".idx"},  32'(idx),  32'(j));
            checkOutput({tag, ".mag"},  32'(mag),  (j == expIdx) ? 32'(expMag) : 32'd0);
            checkOutput({tag, ".done"}, 32'(done), (j == 0) ? 32'd1 : 32'd0);
            if (j == 0) begin
                checkOutput({tag, ".fail"}, 32'(fail), 32'(expFail));
`ifdef S3_CHIEN_FORNEY_ERRCNT_EN
                checkOutput({tag, ".errcnt"}, 32'(errcnt), 32'(expCnt));
`else
                if (expCnt > 2'd3) $display("[TB] unreachable");
`endif
            end
            @(negedge clk);
        end
    endtask

    task automatic runCodeword(input string tag, input logic [7:0] l0, input logic [7:0] l1,
                               input logic [7:0] l2, input logic [7:0] o0, input logic [7:0] o1,
                               input int expIdx, input logic [7:0] expMag,
                               input logic expFail, input logic [1:0] expCnt);
        applyStimulus(l0, l1, l2, o0, o1);
        checkOutput({tag, ".lat0"}, 32'(vld), 32'd0);
        @(negedge clk);
        checkOutput({tag, ".lat1"}, 32'(vld), 32'd0);
        @(negedge clk);
        checkStream(tag, expIdx, expMag, expFail, expCnt);
        checkOutput({tag, ".idle"}, 32'(vld), 32'd0);
    endtask

    initial begin
        int sawVld;
        int sawDone;
        rst = 1'b1; kesDone = 1'b0;
        lam0 = '0; lam1 = '0; lam2 = '0; om0 = '0; om1 = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        checkOutput("rst.vld",  32'(vld),    32'd0);
        checkOutput("rst.rdy",  32'(kesRdy), 32'd1);
        checkOutput("rst.ovf",  32'(ovf),    32'd0);
        checkOutput("rst.done", 32'(done),   32'd0);
        checkOutput("rst.mag",  32'(mag),    32'd0);
        @(negedge clk);

        // Single error at position 10 (a^10 = 0x74) with magnitude 0x5A.
        runCodeword("t1", 8'h01, 8'h74, 8'h00, 8'h5A, 8'h00, 10, 8'h5A, 1'b0, 2'd1);
        runCodeword("t2", 8'h01, 8'h00, 8'h00, 8'h00, 8'h00, -1, 8'h00, 1'b0, 2'd0);
        // Same codeword with all coefficients scaled by 0x03: 03*74=9C, 03*5A=EE.
        runCodeword("t3", 8'h03, 8'h9C, 8'h00, 8'hEE, 8'h00, 10, 8'h5A, 1'b0, 2'd1);
        // (1+x)^2: double root at position 0, derivative zero.
        runCodeword("t4", 8'h01, 8'h00, 8'h01, 8'h00, 8'h00, -1, 8'h00, 1'b1, 2'd1);

        checkOutput("t5.ovf0", 32'(ovf), 32'd0);
        fork
            begin
                applyStimulus(8'h01, 8'h74, 8'h00, 8'h5A, 8'h00);
                repeat (4) @(negedge clk);
                applyStimulus(8'h01, 8'h00, 8'h01, 8'h00, 8'h00);
                checkOutput("t5.rdyLow", 32'(kesRdy), 32'd0);
                checkOutput("t5.ovf1",   32'(ovf),    32'd0);
                repeat (4) @(negedge clk);
                applyStimulus(8'h01, 8'h00, 8'h00, 8'h00, 8'h00);
                checkOutput("t5.ovfSet", 32'(ovf),    32'd1);
                checkOutput("t5.rdyLo2", 32'(kesRdy), 32'd0);
            end
            begin
                repeat (3) @(negedge clk);
                checkStream("t5a", 10, 8'h5A, 1'b0, 2'd1);
                checkStream("t5b", -1, 8'h00, 1'b1, 2'd1);
            end
        join
        checkOutput("t5.idle", 32'(vld), 32'd0);
        repeat (5) @(negedge clk);
        checkOutput("t5.dropped", 32'(vld), 32'd0);
        checkOutput("t5.rdyBack", 32'(kesRdy), 32'd1);

        applyStimulus(8'h01, 8'h74, 8'h00, 8'h5A, 8'h00);
        repeat (101) @(negedge clk);
        checkOutput("t6.midRun", 32'(vld), 32'd1);
        rst = 1'b1;
        #1;
        checkOutput("t6.vld", 32'(vld),    32'd0);
        checkOutput("t6.idx", 32'(idx),    32'd0);
        checkOutput("t6.ovf", 32'(ovf),    32'd0);
        checkOutput("t6.rdy", 32'(kesRdy), 32'd1);
        @(negedge clk);
        rst = 1'b0;
        sawVld = 0;
        sawDone = 0;
        for (int c = 0; c < 300; c++) begin
            @(negedge clk);
            if (vld)  sawVld++;
            if (done) sawDone++;
        end
        checkOutput("t6.noVld",  32'(sawVld),  32'd0);
        checkOutput("t6.noDone", 32'(sawDone), 32'd0);
        runCodeword("t6r", 8'h01, 8'h74, 8'h00, 8'h5A, 8'h00, 10, 8'h5A, 1'b0, 2'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
